// File: rtl/dsp_inverse.sv
// Sequential restoring divider recovering the pre-adder value M = (P -/+ C) / A
// from a DSP slice result, with remainder and divide-by-zero flag.
module dsp_inverse #(
    parameter string OPERATION = "ADD"
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] P_in,
    input  logic [47:0] C_in,
    input  logic [17:0] A_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] Q,
    output logic [17:0] R,
    output logic        dz
);
    localparam bit IS_SUB = (OPERATION == "SUBTRACT");

    generate
        if (OPERATION != "ADD" && OPERATION != "SUBTRACT") begin : g_cfg_err
            $error("dsp_inverse: OPERATION must be \"ADD\" or \"SUBTRACT\"");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;

    state_t      state, state_nx;
    logic [47:0] p_r, c_r, dividend;
    logic [17:0] a_r;
    logic [17:0] rem;
    logic [5:0]  cnt;

    logic [47:0] prep_div;
    logic [18:0] rem_sh;
    logic        rem_ge;
    logic [17:0] rem_nx;

    // Undo the slice's post-adder; carry/borrow out is dropped.
    assign prep_div = IS_SUB ? (p_r + c_r) : (p_r - c_r);

    // The shifted value needs 19 bits, but the kept remainder is < A and fits in 18.
    assign rem_sh = {rem, dividend[cnt]};
    assign rem_ge = (rem_sh >= {1'b0, a_r});
    assign rem_nx = rem_ge ? 18'(rem_sh - {1'b0, a_r}) : rem_sh[17:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            p_r      <= '0;
            c_r      <= '0;
            a_r      <= '0;
            dividend <= '0;
            rem      <= '0;
            cnt      <= '0;
            Q        <= '0;
            R        <= '0;
            dz       <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        p_r <= P_in;
                        c_r <= C_in;
                        a_r <= A_in;
                    end
                end
                PREP: begin
                    dividend <= prep_div;
                    if (a_r == '0) begin
                        Q  <= '1;
                        R  <= prep_div[17:0];
                        dz <= 1'b1;
                    end else begin
                        rem <= '0;
                        cnt <= 6'd47;
                        dz  <= 1'b0;
                    end
                end
                DIV: begin
                    rem    <= rem_nx;
                    Q[cnt] <= rem_ge;
                    cnt    <= cnt - 6'd1;
                    if (cnt == '0) R <= rem_nx;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = PREP;
            end
            PREP: state_nx = (a_r == '0) ? DONE : DIV;
            DIV:  if (cnt == '0) state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule
